instruction_queue: RTL
======================

# instruction_queue

Circular FIFO between the fetch stage and decode/dispatch. Each cycle in which fetch presents a valid instruction, the queue captures the returned instruction word together with its `inst_info_t` tag (pc, pc_next, order). It presents the oldest entry to decode and back-pressures fetch through `iq_is_full`. On a branch flush, all contents are discarded in a single cycle.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `iq_enqueue`  in  1  fetch offers an entry this cycle
- `imem_resp`  in  1  instruction memory returned data this cycle
- `imem_rdata`  in  32  instruction word
- `inst_info`  in  inst_info_t  pc, pc_next and order of the offered instruction
- `flush`  in  1  mispredict recovery; discard all entries
- `iq_dequeue`  in  1  decode consumes the head entry
- `iq_is_full`  out  1  count == DEPTH
- `iq_is_empty`  out  1  count == 0
- `iq_head`  out  iq_entry_t  oldest entry: inst, pc, pc_next, order
- `iq_count`  out  $clog2(DEPTH)+1  occupancy
- `iq_is_almost_full`  out  1  present only under `IQ_ALMOST_FULL_EN`

## Operation
- Pointers:
  - `head` and `tail` are each $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - Index is the low bits. Increment is modulo 2·DEPTH.
  - full = low bits equal and MSBs differ; empty = pointers equal.
- Accept (enqueue) = `iq_enqueue && imem_resp && !iq_is_full && !flush`. Writes {imem_rdata, inst_info} at tail, then tail+1.
- Pop (dequeue) = `iq_dequeue && !iq_is_empty && !flush`. Increments head; entry contents are not cleared.
- Enqueue with `iq_is_full`=1 is dropped silently. Fetch must hold its pc.
- Dequeue with `iq_is_empty`=1 is ignored. There is no empty bypass.
- Simultaneous accept and pop: both occur and the count is unchanged.
  - When full, pop happens and enqueue is refused, because full is evaluated on the current state.
  - When empty, the enqueue happens and the pop is ignored.
- Flush has priority over everything:
  - head and tail go to 0 and count goes to 0 the next cycle.
  - Any same-cycle enqueue is discarded.
- Count is updated as count + accept − pop. It never exceeds DEPTH and never underflows.
- `iq_head` is a combinational read of storage[head]. It is undefined (X permitted) while empty; the bench checks it only when `iq_is_empty`=0.

## Timing
- Reset (async assert, sync deassert via the top): head=0, tail=0, count=0, `iq_is_empty`=1, `iq_is_full`=0, `iq_is_almost_full`=0. Storage is not reset.
- Enqueue-to-visible latency is 1 cycle: an entry accepted at edge N appears on `iq_head` (empty=0) after edge N.
- `iq_is_full`, `iq_is_empty`, `iq_count` and `iq_is_almost_full` are functions of registered state only. They do not depend combinationally on any input.
- Flush asserted at edge N: `iq_is_empty`=1 after edge N, and a new enqueue is accepted at edge N+1.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- `IQ_ALMOST_FULL_EN` defined:
  - The `iq_is_almost_full` port exists and asserts when count ≥ DEPTH−1.
  - Fetch uses it to stop issuing one cycle early, covering its one-cycle imem response latency.
- Not defined: the port is absent. Only `iq_is_full` gives back-pressure, and an over-issued fetch is dropped per the accept rule.

## Structure
- `rv32i_types` holds:
  - `iq_entry_t` (inst[31:0], pc[31:0], pc_next[31:0], order[63:0])
  - `IQ_DEPTH` = 16, used as the top-level default
- One sub-module, `iq_storage`: a DEPTH × `iq_entry_t` register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata).
- Pointer, count and flag logic stay in `instruction_queue`.

## Test plan
- Reset, then 3 enqueues (pc 0x60000000, 0x60000004, 0x60000008, order 0..2) → after each edge `iq_head`.pc=0x60000000, count=1, 2, 3. Three dequeues then return the pcs in order, ending with empty=1.
- 16 consecutive enqueues → full=1 at count=16. A 17th enqueue with imem_resp=1 is dropped, and tail/count are unchanged.
- Full queue, enqueue and dequeue in the same cycle → count=15, full=0, head advances by one, and the offered entry is lost.
- Empty queue, enqueue and dequeue in the same cycle → count=1, and the entry is visible at the head.
- 10 entries queued, then flush plus enqueue plus dequeue in one cycle → next cycle empty=1, count=0. The following enqueue (pc=0x60000100) appears at the head one cycle later.
- Pointer wrap: 40 mixed enqueue/dequeue operations at occupancy 8–15 → FIFO order is preserved across the index wrap and the full/empty flags stay correct. With `IQ_ALMOST_FULL_EN`, almost_full=1 exactly when count ≥ 15.

Source files
------------

// File: rtl/instruction_queue_pkg.sv
// Shared types for the instruction queue: per-instruction tag from fetch
// and the stored queue entry, plus the default queue depth.
package rv32i_types;

    localparam int IQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
    } inst_info_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
    } iq_entry_t;

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch/decode-facing bundle of the instruction queue.
// Optional IQ_ALMOST_FULL_EN adds the iq_is_almost_full early back-pressure flag.
interface instruction_queue_if
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             iq_enqueue;
    logic             imem_resp;
    logic [31:0]      imem_rdata;
    inst_info_t       inst_info;
    logic             flush;
    logic             iq_dequeue;
    logic             iq_is_full;
    logic             iq_is_empty;
    iq_entry_t        iq_head;
    logic [CNT_W-1:0] iq_count;
`ifdef IQ_ALMOST_FULL_EN
    logic             iq_is_almost_full;

    modport master (
        output iq_enqueue, imem_resp, imem_rdata, inst_info, flush, iq_dequeue,
        input  iq_is_full, iq_is_empty, iq_head, iq_count, iq_is_almost_full
    );

    modport slave (
        input  iq_enqueue, imem_resp, imem_rdata, inst_info, flush, iq_dequeue,
        output iq_is_full, iq_is_empty, iq_head, iq_count, iq_is_almost_full
    );
`else
    modport master (
        output iq_enqueue, imem_resp, imem_rdata, inst_info, flush, iq_dequeue,
        input  iq_is_full, iq_is_empty, iq_head, iq_count
    );

    modport slave (
        input  iq_enqueue, imem_resp, imem_rdata, inst_info, flush, iq_dequeue,
        output iq_is_full, iq_is_empty, iq_head, iq_count
    );
`endif

endinterface

// File: rtl/instruction_queue_storage.sv
// Entry array of the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are never reset or cleared.
module iq_storage
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
)
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  iq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output iq_entry_t                rdata
);

    iq_entry_t mem [DEPTH];

    // Capture the accepted entry at the tail slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// Circular FIFO between fetch and decode. Pointers carry a wrap bit so full
// and empty are distinguishable; flush empties the queue in one cycle.
// Optional IQ_ALMOST_FULL_EN drives iq_is_almost_full when count >= DEPTH-1.
module instruction_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
)
(
    input  logic                clk,
    input  logic                rst_n,
    instruction_queue_if.slave  iq
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
`ifdef IQ_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - 1);
`endif

    logic [1:0]       rst_sync;
    logic             rst_n_int;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    iq_entry_t        wdata;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    assign full   = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[PTR_W-1] != tail[PTR_W-1]);
    assign empty  = (head == tail);
    assign accept = iq.iq_enqueue && iq.imem_resp && !full && !iq.flush;
    assign pop    = iq.iq_dequeue && !empty && !iq.flush;

    assign wdata = '{inst:    iq.imem_rdata,
                     pc:      iq.inst_info.pc,
                     pc_next: iq.inst_info.pc_next,
                     order:   iq.inst_info.order};

    // Advance pointers and occupancy; flush wins over any same-cycle traffic
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (iq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + PTR_W'(accept) - PTR_W'(pop);
        end
    end

    iq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (accept),
        .waddr (tail[IDX_W-1:0]),
        .wdata (wdata),
        .raddr (head[IDX_W-1:0]),
        .rdata (iq.iq_head)
    );

    assign iq.iq_is_full  = full;
    assign iq.iq_is_empty = empty;
    assign iq.iq_count    = count;
`ifdef IQ_ALMOST_FULL_EN
    assign iq.iq_is_almost_full = (count >= AF_LEVEL);
`endif

endmodule
